// File: rtl/stack_alu_seq_pkg.sv
// Shared opcode encodings, FSM state encoding and width helpers for the stack ALU.
package stack_alu_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_PUSH = 4'b1010;
  localparam logic [3:0] OP_POP  = 4'b1011;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_DUP  = 4'b1101;
  localparam logic [3:0] OP_SWAP = 4'b1110;
  localparam logic [3:0] OP_CLR  = 4'b1111;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  // Width of an index into an array of 'entries' elements (at least 1 bit).
  function automatic int idx_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Width of a counter that must hold the values 0..entries inclusive.
  function automatic int cnt_width(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/stack_alu_seq_if.sv
// Operation handshake and result/status bundle between command source and stack ALU.
interface stack_alu_seq_if
  import stack_alu_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8
);
  localparam int DW = cnt_width(DEPTH);

  logic                op_valid;
  logic                op_ready;
  logic [3:0]          opcode;
  logic signed [N-1:0] in_data;
  logic signed [N-1:0] out_data;
  logic                out_valid;
  logic                overflow;
  logic                err;
  logic [DW-1:0]       depth;
  logic                full;
  logic                empty;

  modport master (
    output op_valid, opcode, in_data,
    input  op_ready, out_data, out_valid, overflow, err, depth, full, empty
  );

  modport slave (
    input  op_valid, opcode, in_data,
    output op_ready, out_data, out_valid, overflow, err, depth, full, empty
  );
endinterface

// File: rtl/stack_alu_seq_mul.sv
// N-cycle signed shift-add multiplier. The last partial product (sign bit of b)
// is subtracted and folded in combinationally, so done_o/prod_o are valid in the
// N-th cycle after start_i and the caller captures them on that edge.
module stack_alu_seq_mul
  import stack_alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] prod_o
);
  localparam int CW = cnt_width(N);

  logic [2*N-1:0] acc_q, a_q, acc_d, part;
  logic [N-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           last;

  // One partial product per cycle; the sign bit's weight is negative.
  always_comb begin
    last   = busy_q && (cnt_q == CW'(1));
    part   = b_q[0] ? a_q : '0;
    acc_d  = last ? (acc_q - part) : (acc_q + part);
    done_o = last;
    prod_o = acc_d;
  end

  // Operand shift registers, accumulator and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      acc_q  <= '0;
      a_q    <= {{N{a_i[N-1]}}, a_i};
      b_q    <= b_i;
      cnt_q  <= CW'(N);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - CW'(1);
      if (last) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/stack_alu_seq.sv
// Signed LIFO stack ALU with valid/ready op handshake and a sequential multiplier.
//   state       | meaning
//   ST_IDLE     | op_ready=1, single-cycle ops complete on the accepting edge
//   ST_MUL_BUSY | op_ready=0, waiting for the multiplier's done pulse
module stack_alu_seq
  import stack_alu_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  stack_alu_seq_if.slave bus
);
  localparam int DW = cnt_width(DEPTH);
  localparam int AW = idx_width(DEPTH);

  logic [N-1:0]    stack_q [DEPTH];
  logic [DW-1:0]   sp_q, sp_d;
  logic [N-1:0]    out_q, out_d;
  logic            vld_q, vld_d, ov_q, ov_d, err_q, err_d;
  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   idx_p, idx_t, idx_s;
  logic [N-1:0]    top_v, sec_v;
  logic [N:0]      add_x, sub_x, mul_hi;
  logic            fire, has2, full, empty;
  logic            mul_start, mul_done;
  logic [2*N-1:0]  mul_prod;
  logic            wr0_en, wr1_en;
  logic [AW-1:0]   wr0_idx, wr1_idx;
  logic [N-1:0]    wr0_dat, wr1_dat;

  assign idx_p  = AW'(sp_q);
  assign idx_t  = AW'(sp_q - DW'(1));
  assign idx_s  = AW'(sp_q - DW'(2));
  assign top_v  = stack_q[idx_t];
  assign sec_v  = stack_q[idx_s];
  assign add_x  = {sec_v[N-1], sec_v} + {top_v[N-1], top_v};
  assign sub_x  = {sec_v[N-1], sec_v} - {top_v[N-1], top_v};
  assign mul_hi = mul_prod[2*N-1:N-1];
  assign full   = (sp_q == DW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign has2   = (sp_q >= DW'(2));
  assign fire   = bus.op_valid && (state_q == ST_IDLE);

  stack_alu_seq_mul #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (sec_v),
    .b_i     (top_v),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Decode the accepted op (or multiplier completion) into next state and stack writes.
  always_comb begin
    sp_d      = sp_q;
    out_d     = out_q;
    vld_d     = 1'b0;
    ov_d      = 1'b0;
    err_d     = 1'b0;
    state_d   = state_q;
    mul_start = 1'b0;
    wr0_en    = 1'b0;
    wr0_idx   = idx_p;
    wr0_dat   = bus.in_data;
    wr1_en    = 1'b0;
    wr1_idx   = idx_s;
    wr1_dat   = top_v;
    if (state_q == ST_MUL_BUSY) begin
      if (mul_done) begin
        wr0_en  = 1'b1;
        wr0_idx = idx_s;
        wr0_dat = mul_prod[N-1:0];
        sp_d    = sp_q - DW'(1);
        out_d   = mul_prod[N-1:0];
        ov_d    = !((&mul_hi) || !(|mul_hi));
        vld_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (fire) begin
      vld_d = 1'b1;
      unique case (bus.opcode)
        OP_ADD, OP_SUB: begin
          if (!has2) err_d = 1'b1;
          else begin
            wr0_en  = 1'b1;
            wr0_idx = idx_s;
            wr0_dat = (bus.opcode == OP_ADD) ? add_x[N-1:0] : sub_x[N-1:0];
            out_d   = wr0_dat;
            ov_d    = (bus.opcode == OP_ADD) ? (add_x[N] != add_x[N-1])
                                             : (sub_x[N] != sub_x[N-1]);
            sp_d    = sp_q - DW'(1);
          end
        end
        OP_MUL: begin
          if (!has2) err_d = 1'b1;
          else begin
            vld_d     = 1'b0;
            mul_start = 1'b1;
            state_d   = ST_MUL_BUSY;
          end
        end
        OP_PUSH: begin
          if (full) err_d = 1'b1;
          else begin
            wr0_en = 1'b1;
            sp_d   = sp_q + DW'(1);
          end
        end
        OP_POP: begin
          if (empty) err_d = 1'b1;
          else begin
            out_d = top_v;
            sp_d  = sp_q - DW'(1);
          end
        end
        OP_DUP: begin
          if (full || empty) err_d = 1'b1;
          else begin
            wr0_en  = 1'b1;
            wr0_dat = top_v;
            sp_d    = sp_q + DW'(1);
          end
        end
        OP_SWAP: begin
          if (!has2) err_d = 1'b1;
          else begin
            wr0_en  = 1'b1;
            wr0_idx = idx_t;
            wr0_dat = sec_v;
            wr1_en  = 1'b1;
          end
        end
        OP_CLR:  sp_d  = '0;
        default: vld_d = 1'b0;
      endcase
    end
  end

  // Stack storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr0_en) stack_q[wr0_idx] <= wr0_dat;
    if (wr1_en) stack_q[wr1_idx] <= wr1_dat;
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      sp_q    <= sp_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign bus.op_ready  = (state_q == ST_IDLE);
  assign bus.out_data  = out_q;
  assign bus.out_valid = vld_q;
  assign bus.overflow  = ov_q;
  assign bus.err       = err_q;
  assign bus.depth     = sp_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
endmodule

// File: tb/tb_stack_alu_seq.sv
// Directed checks of the stack ALU: arithmetic, stack errors, MUL handshake and reset abort.
module tb_stack_alu_seq;
  localparam logic [3:0] NOP = 4'b0000, ADD = 4'b1000, MUL = 4'b1001, PUSH = 4'b1010,
                         POP = 4'b1011, SUB = 4'b1100, DUP = 4'b1101, SWAP = 4'b1110,
                         CLR = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  stack_alu_seq_if #(.N(4), .DEPTH(8)) bus ();
  stack_alu_seq #(.N(4), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Callers sit 1 time unit after a rising edge; returns at the same phase after the op's edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] val);
    bus.op_valid = 1'b1;
    bus.opcode   = op;
    bus.in_data  = val;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_mul(input string nm);
    int k;
    for (k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) break;
    end
    n_chk++;
    if (k == 16) begin n_fail++; $display("FAIL %s_timeout: out_valid never rose within 16 cycles", nm); end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL rst_out: got %h want 0", bus.out_data); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.op_ready); end
    n_chk++; if (bus.depth !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL rst_depth: depth %0d empty %b full %b want 0 1 0", bus.depth, bus.empty, bus.full); end
  endtask

  task automatic test_add_sub();
    do_reset();
    issue(PUSH, 4'd5);
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL push_resp: vld %b out %h err %b want 1 0 0", bus.out_valid, bus.out_data, bus.err); end
    issue(PUSH, 4'd3);
    issue(ADD, 4'd0);
    n_chk++; if (bus.out_data !== 4'b1000) begin n_fail++; $display("FAIL add_out: got %b want 1000", bus.out_data); end
    n_chk++; if (bus.overflow !== 1'b1 || bus.err !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL add_flags: ov %b err %b vld %b want 1 0 1", bus.overflow, bus.err, bus.out_valid); end
    n_chk++; if (bus.depth !== 4'd1) begin n_fail++; $display("FAIL add_depth: got %0d want 1", bus.depth); end
    do_reset();
    issue(PUSH, 4'd2);
    issue(PUSH, 4'd5);
    issue(SUB, 4'd0);
    n_chk++; if (bus.out_data !== 4'b1101 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL sub_out: out %b ov %b want 1101 0", bus.out_data, bus.overflow); end
    n_chk++; if (bus.depth !== 4'd1) begin n_fail++; $display("FAIL sub_depth: got %0d want 1", bus.depth); end
    // -8 - 1 = -9 overflows to +7
    issue(PUSH, 4'b1000);
    issue(PUSH, 4'd1);
    issue(SUB, 4'd0);
    n_chk++; if (bus.out_data !== 4'b0111 || bus.overflow !== 1'b1 || bus.depth !== 4'd2) begin
      n_fail++; $display("FAIL sub_ovf: out %b ov %b depth %0d want 0111 1 2", bus.out_data, bus.overflow, bus.depth); end
    issue(NOP, 4'd0);
    n_chk++; if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.depth !== 4'd2) begin
      n_fail++; $display("FAIL nop: vld %b ov %b depth %0d want 0 0 2", bus.out_valid, bus.overflow, bus.depth); end
  endtask

  task automatic test_mul();
    do_reset();
    issue(PUSH, 4'd3);
    issue(PUSH, 4'd2);
    bus.op_valid = 1'b1;
    bus.opcode   = MUL;
    @(posedge clk); #1;
    n_chk++; if (bus.op_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mul_accept: ready %b vld %b want 0 0", bus.op_ready, bus.out_valid); end
    bus.opcode  = PUSH;
    bus.in_data = 4'd7;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      n_chk++; if (bus.op_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.depth !== 4'd2) begin
        n_fail++; $display("FAIL mul_busy%0d: ready %b vld %b depth %0d want 0 0 2", i, bus.op_ready, bus.out_valid, bus.depth); end
    end
    @(posedge clk); #1;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd6 || bus.overflow !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL mul_result: vld %b out %h ov %b err %b want 1 6 0 0", bus.out_valid, bus.out_data, bus.overflow, bus.err); end
    n_chk++; if (bus.depth !== 4'd1 || bus.op_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_done_state: depth %0d ready %b want 1 1", bus.depth, bus.op_ready); end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    n_chk++; if (bus.depth !== 4'd2 || bus.out_valid !== 1'b1 || bus.out_data !== 4'd6) begin
      n_fail++; $display("FAIL held_push: depth %0d vld %b out %h want 2 1 6", bus.depth, bus.out_valid, bus.out_data); end
    // 6 * 7 = 42 -> truncated 1010, overflow
    issue(MUL, 4'd0);
    wait_mul("mul_ovf");
    n_chk++; if (bus.out_data !== 4'b1010 || bus.overflow !== 1'b1 || bus.depth !== 4'd1) begin
      n_fail++; $display("FAIL mul_ovf: out %b ov %b depth %0d want 1010 1 1", bus.out_data, bus.overflow, bus.depth); end
    // -2 * 3 = -6, fits
    do_reset();
    issue(PUSH, 4'b1110);
    issue(PUSH, 4'd3);
    issue(MUL, 4'd0);
    wait_mul("mul_neg");
    n_chk++; if (bus.out_data !== 4'b1010 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL mul_neg: out %b ov %b want 1010 0", bus.out_data, bus.overflow); end
    // MUL with one operand is an error and must not start the multiplier
    issue(MUL, 4'd0);
    n_chk++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b1 || bus.op_ready !== 1'b1 || bus.depth !== 4'd1) begin
      n_fail++; $display("FAIL mul_err: err %b vld %b ready %b depth %0d want 1 1 1 1", bus.err, bus.out_valid, bus.op_ready, bus.depth); end
  endtask

  task automatic test_stack_errors();
    do_reset();
    issue(POP, 4'd0);
    n_chk++; if (bus.err !== 1'b1 || bus.out_valid !== 1'b1 || bus.depth !== 4'd0 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL pop_empty: err %b vld %b depth %0d empty %b want 1 1 0 1", bus.err, bus.out_valid, bus.depth, bus.empty); end
    for (int i = 1; i <= 8; i++) issue(PUSH, 4'(i));
    n_chk++; if (bus.err !== 1'b0 || bus.full !== 1'b1 || bus.depth !== 4'd8) begin
      n_fail++; $display("FAIL push8: err %b full %b depth %0d want 0 1 8", bus.err, bus.full, bus.depth); end
    issue(PUSH, 4'd9);
    n_chk++; if (bus.err !== 1'b1 || bus.full !== 1'b1 || bus.depth !== 4'd8 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL push9: err %b full %b depth %0d ov %b want 1 1 8 0", bus.err, bus.full, bus.depth, bus.overflow); end
    issue(DUP, 4'd0);
    n_chk++; if (bus.err !== 1'b1 || bus.depth !== 4'd8) begin
      n_fail++; $display("FAIL dup_full: err %b depth %0d want 1 8", bus.err, bus.depth); end
    issue(POP, 4'd0);
    n_chk++; if (bus.out_data !== 4'd8 || bus.err !== 1'b0 || bus.depth !== 4'd7) begin
      n_fail++; $display("FAIL pop_top: out %h err %b depth %0d want 8 0 7", bus.out_data, bus.err, bus.depth); end
    issue(CLR, 4'd0);
    n_chk++; if (bus.depth !== 4'd0 || bus.out_valid !== 1'b1 || bus.out_data !== 4'd8) begin
      n_fail++; $display("FAIL clr: depth %0d vld %b out %h want 0 1 8", bus.depth, bus.out_valid, bus.out_data); end
    issue(PUSH, 4'd4);
    issue(ADD, 4'd0);
    n_chk++; if (bus.err !== 1'b1 || bus.depth !== 4'd1 || bus.out_data !== 4'd8) begin
      n_fail++; $display("FAIL add_short: err %b depth %0d out %h want 1 1 8", bus.err, bus.depth, bus.out_data); end
  endtask

  task automatic test_dup_swap();
    do_reset();
    issue(PUSH, 4'd7);
    issue(DUP, 4'd0);
    n_chk++; if (bus.depth !== 4'd2 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL dup: depth %0d err %b want 2 0", bus.depth, bus.err); end
    issue(SWAP, 4'd0);
    issue(POP, 4'd0);
    n_chk++; if (bus.out_data !== 4'd7) begin n_fail++; $display("FAIL dup_pop1: got %h want 7", bus.out_data); end
    issue(POP, 4'd0);
    n_chk++; if (bus.out_data !== 4'd7 || bus.depth !== 4'd0) begin
      n_fail++; $display("FAIL dup_pop2: out %h depth %0d want 7 0", bus.out_data, bus.depth); end
    issue(PUSH, 4'd1);
    issue(PUSH, 4'd2);
    issue(SWAP, 4'd0);
    n_chk++; if (bus.out_data !== 4'd7 || bus.out_valid !== 1'b1 || bus.depth !== 4'd2) begin
      n_fail++; $display("FAIL swap_resp: out %h vld %b depth %0d want 7 1 2", bus.out_data, bus.out_valid, bus.depth); end
    issue(POP, 4'd0);
    n_chk++; if (bus.out_data !== 4'd1) begin n_fail++; $display("FAIL swap_pop1: got %h want 1", bus.out_data); end
    issue(POP, 4'd0);
    n_chk++; if (bus.out_data !== 4'd2) begin n_fail++; $display("FAIL swap_pop2: got %h want 2", bus.out_data); end
  endtask

  task automatic test_reset_mid_mul();
    bit seen_vld;
    do_reset();
    issue(PUSH, 4'd5);
    issue(POP, 4'd0);
    issue(PUSH, 4'b1000);
    issue(PUSH, 4'b1111);
    issue(MUL, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.op_ready !== 1'b1 || bus.depth !== 4'd0 || bus.out_data !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_mul: ready %b depth %0d out %h vld %b want 1 0 0 0", bus.op_ready, bus.depth, bus.out_data, bus.out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_vld = 1'b1;
    end
    n_chk++; if (seen_vld !== 1'b0 || bus.op_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_abort: stray vld %b ready %b want 0 1", seen_vld, bus.op_ready); end
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.opcode   = NOP;
    bus.in_data  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add_sub();
    test_mul();
    test_stack_errors();
    test_dup_swap();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
